// File: rtl/hex_scan_driver_if.sv
// Debug-nibble / seven-segment bundle between the debug selector and hex_scan_driver.
// The master is the selector side; the slave is the scan driver.
interface hex_scan_driver_if;
  logic [3:0] Hex7;
  logic [3:0] Hex6;
  logic [3:0] Hex5;
  logic [3:0] Hex4;
  logic       Freeze;
  logic [6:0] Seg;
  logic [3:0] DigitEn;
  logic       FrameStrobe;

  modport master (
    output Hex7, Hex6, Hex5, Hex4, Freeze,
    input  Seg, DigitEn, FrameStrobe
  );

  modport slave (
    input  Hex7, Hex6, Hex5, Hex4, Freeze,
    output Seg, DigitEn, FrameStrobe
  );
endinterface

// File: rtl/hex_scan_driver.sv
// Captures a 4-nibble debug frame and time-multiplexes it onto an active-low 7-segment bus.
// Optional macro HEX_SCAN_LEAD_ZERO_BLANK_EN blanks leading-zero digits (Hex4 never blanked).
module hex_scan_driver #(
  parameter int DIGIT_TICKS = 50000
) (
  input  logic            Clk,
  input  logic            Reset,
  hex_scan_driver_if.slave bus
);

  localparam int CNT_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DIGIT_TICKS - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_frame;
  logic             r_strobe;
  logic [6:0]       r_seg;
  logic [3:0]       r_digit_en;

  logic             w_load;
  logic [15:0]      w_frame;
  logic [3:0]       w_nib;
  logic             w_lead_zero;
  logic [6:0]       w_seg;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      4'hF: return 7'h0E;
    endcase
  endfunction

  // Segment value for the slot about to start; sees a frame being loaded this same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_nib       = w_frame[3:0];
    w_lead_zero = 1'b0;
    w_load      = (r_state == BLANK) && (r_idx == 2'd0) && !bus.Freeze;
    w_frame     = w_load ? {bus.Hex7, bus.Hex6, bus.Hex5, bus.Hex4} : r_frame;
    case (r_idx)
      2'd0: begin w_nib = w_frame[15:12]; w_lead_zero = (w_frame[15:12] == 4'h0); end
      2'd1: begin w_nib = w_frame[11:8];  w_lead_zero = (w_frame[15:8]  == 8'h0); end
      2'd2: begin w_nib = w_frame[7:4];   w_lead_zero = (w_frame[15:4]  == 12'h0); end
      2'd3: begin w_nib = w_frame[3:0];   w_lead_zero = 1'b0; end
    endcase
`ifdef HEX_SCAN_LEAD_ZERO_BLANK_EN
    w_seg = w_lead_zero ? 7'h7F : decode(w_nib);
`else
    w_seg = decode(w_nib);
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: the shadow frame is reset too; a frozen display must come up showing zeros.
      r_state    <= BLANK;
      r_idx      <= 2'd0;
      r_cnt      <= '0;
      r_frame    <= 16'h0;
      r_strobe   <= 1'b0;
      r_seg      <= 7'h7F;
      r_digit_en <= 4'hF;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      r_strobe <= w_load;
      case (r_state)
        BLANK: begin
          if (w_load) r_frame <= w_frame;
          r_seg      <= w_seg;
          r_digit_en <= ~(4'b1000 >> r_idx);
          r_state    <= DRIVE;
        end
        DRIVE: begin
          if (r_cnt == LAST_TICK) begin
            r_cnt      <= '0;
            r_idx      <= r_idx + 2'd1;
            r_seg      <= 7'h7F;
            r_digit_en <= 4'hF;
            r_state    <= BLANK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.Seg         = r_seg;
  assign bus.DigitEn     = r_digit_en;
  assign bus.FrameStrobe = r_strobe;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver (DIGIT_TICKS = 4) against a frame-period model.
module tb_hex_scan_driver;
  localparam int T      = 4;
  localparam int SLOT   = T + 1;
  localparam int PERIOD = 4 * SLOT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hex_scan_driver_if bus ();

  hex_scan_driver #(.DIGIT_TICKS(T)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: n = clock edges since reset release, m_frame = frame on display (Hex7 in [15:12]).
  int          n;
  logic [15:0] m_frame;
  logic        m_strobe;
  int          checks = 0;
  int          fails  = 0;

  function automatic logic [11:0] exp_out();
    int p, slot;
    logic [6:0] s;
    logic [3:0] en;
    p = n % PERIOD;
    slot = p / SLOT;
    if (p % SLOT == 0) begin
      s  = 7'h7F;
      en = 4'hF;
    end else begin
      en = ~(4'b0001 << (3 - slot));
      s  = seg_tbl[(m_frame >> (4 * (3 - slot))) & 16'hF];
`ifdef HEX_SCAN_LEAD_ZERO_BLANK_EN
      if (slot < 3 && (m_frame >> (4 * (3 - slot))) == 16'h0) s = 7'h7F;
`endif
    end
    return {s, en, m_strobe};
  endfunction

  task automatic tick();
    logic ld;
    ld = (n % PERIOD == 0) && !bus.Freeze;
    @(posedge clk);
    if (ld) m_frame = {bus.Hex7, bus.Hex6, bus.Hex5, bus.Hex4};
    n++;
    m_strobe = ld;
    @(negedge clk);
  endtask

  task automatic set_hex(input logic [15:0] v);
    {bus.Hex7, bus.Hex6, bus.Hex5, bus.Hex4} = v;
  endtask

  task automatic test_reset();
    set_hex(16'h1234);
    bus.Freeze = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== {7'h7F, 4'hF, 1'b0}) begin
      fails++;
      $display("FAIL reset_hold: got %h/%h/%b want 7f/f/0", bus.Seg, bus.DigitEn, bus.FrameStrobe);
    end
    rst = 1'b0;
    n = 0; m_frame = 16'h0; m_strobe = 1'b0;
    checks++;
    if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== exp_out()) begin
      fails++;
      $display("FAIL reset_release: got %h/%h/%b want %h", bus.Seg, bus.DigitEn, bus.FrameStrobe, exp_out());
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 2 * PERIOD; i++) begin
      tick();
      checks++;
      if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== exp_out()) begin
        fails++;
        $display("FAIL basic n=%0d: got %h/%h/%b want %h", n, bus.Seg, bus.DigitEn, bus.FrameStrobe, exp_out());
      end
      if (n == 1) begin
        checks++;
        if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== {7'h79, 4'b0111, 1'b1}) begin
          fails++;
          $display("FAIL basic_first_slot: got %h/%h/%b want 79/7/1", bus.Seg, bus.DigitEn, bus.FrameStrobe);
        end
      end
    end
  endtask

  task automatic test_midframe();
    for (int i = 0; i < PERIOD && (n % PERIOD) != SLOT + 1; i++) begin
      tick();
      checks++;
      if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== exp_out()) begin
        fails++;
        $display("FAIL midframe_align n=%0d: got %h/%h/%b want %h", n, bus.Seg, bus.DigitEn, bus.FrameStrobe, exp_out());
      end
    end
    set_hex(16'hABCD);
    for (int i = 0; i < 2 * PERIOD; i++) begin
      tick();
      checks++;
      if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== exp_out()) begin
        fails++;
        $display("FAIL midframe n=%0d: got %h/%h/%b want %h", n, bus.Seg, bus.DigitEn, bus.FrameStrobe, exp_out());
      end
    end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < PERIOD && (n % PERIOD) != 2 * SLOT; i++) tick();
    bus.Freeze = 1'b1;
    set_hex(16'hFFFF);
    for (int i = 0; i < 2 * PERIOD; i++) begin
      tick();
      checks++;
      if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== exp_out()) begin
        fails++;
        $display("FAIL freeze_hold n=%0d: got %h/%h/%b want %h", n, bus.Seg, bus.DigitEn, bus.FrameStrobe, exp_out());
      end
    end
    bus.Freeze = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      tick();
      checks++;
      if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== exp_out()) begin
        fails++;
        $display("FAIL freeze_release n=%0d: got %h/%h/%b want %h", n, bus.Seg, bus.DigitEn, bus.FrameStrobe, exp_out());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < PERIOD && (n % PERIOD) != 2 * SLOT + 2; i++) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== {7'h7F, 4'hF, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: got %h/%h/%b want 7f/f/0", bus.Seg, bus.DigitEn, bus.FrameStrobe);
    end
    bus.Freeze = 1'b1;
    set_hex(16'($urandom_range(1, 16'hFFFF)));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0; m_frame = 16'h0; m_strobe = 1'b0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      checks++;
      if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== exp_out()) begin
        fails++;
        $display("FAIL async_reset_zero n=%0d: got %h/%h/%b want %h", n, bus.Seg, bus.DigitEn, bus.FrameStrobe, exp_out());
      end
    end
    bus.Freeze = 1'b0;
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 16; v++) begin
      for (int i = 0; i < PERIOD && (n % PERIOD) != 0; i++) tick();
      set_hex({12'($urandom), 4'(v)});
      for (int i = 0; i < PERIOD; i++) begin
        tick();
        checks++;
        if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== exp_out()) begin
          fails++;
          $display("FAIL sweep v=%0d n=%0d: got %h/%h/%b want %h", v, n, bus.Seg, bus.DigitEn, bus.FrameStrobe, exp_out());
        end
      end
    end
  endtask

  task automatic test_patterns();
    logic [15:0] pats [3] = '{16'h0050, 16'h0000, 16'h0300};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < PERIOD && (n % PERIOD) != 0; i++) tick();
      set_hex(pats[k]);
      for (int i = 0; i < PERIOD; i++) begin
        tick();
        checks++;
        if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== exp_out()) begin
          fails++;
          $display("FAIL pattern%0d n=%0d: got %h/%h/%b want %h", k, n, bus.Seg, bus.DigitEn, bus.FrameStrobe, exp_out());
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10 * PERIOD; i++) begin
      set_hex(16'($urandom));
      bus.Freeze = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if ({bus.Seg, bus.DigitEn, bus.FrameStrobe} !== exp_out()) begin
        fails++;
        $display("FAIL random n=%0d: got %h/%h/%b want %h", n, bus.Seg, bus.DigitEn, bus.FrameStrobe, exp_out());
      end
    end
    bus.Freeze = 1'b0;
  endtask

  initial begin
    n = 0; m_frame = 16'h0; m_strobe = 1'b0;
    test_reset();
    test_basic();
    test_midframe();
    test_freeze();
    test_async_reset();
    test_sweep();
    test_patterns();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
